// File: rtl/execute_stage.sv
// RV32I execute stage with an internal register file and a single output register.
//
// An instruction offered on in_valid/in_ready is decoded, its operands are read from
// the register file in the same cycle, and the register file is written at the accept
// edge. The executed result is held in the out_* register until out_ready consumes it.
//
// Ports
//   clock, reset              : rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready        : input handshake
//   instruction, pc           : RV32I instruction word and its address
//   out_valid, out_ready      : output handshake
//   out_rd, out_result, out_we: destination index, result value, write-back flag
//   out_branch_taken          : control transfer taken
//   out_next_pc               : next fetch address
//   out_illegal               : unsupported encoding or out-of-range register index
//   retire_count              : number of accepted legal instructions (wrapping)
module execute_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instruction,
    input  logic [XLEN-1:0]      pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_rd,
    output logic [XLEN-1:0]      out_result,
    output logic                 out_we,
    output logic                 out_branch_taken,
    output logic [XLEN-1:0]      out_next_pc,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] retire_count
);

    localparam int unsigned RegIdxW = $clog2(NUM_REGS);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [XLEN-1:0] regs [NUM_REGS];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] pc_plus4, jalr_sum;
    logic [XLEN-1:0] alu_b, alu_out;
    logic [4:0]      shamt;
    logic            alu_alt;
    logic            accept;

    logic [XLEN-1:0] result_d, next_pc_d;
    logic            writes_rd, taken_d, illegal_d, we_d, br_cond;
    logic            uses_rs1, uses_rs2;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // x0 is hardwired to zero; high index bits are ignored here and caught by decode.
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[RegIdxW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[RegIdxW-1:0]];

    assign pc_plus4 = pc + XLEN'(4);
    assign jalr_sum = rs1_val + imm_i;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Shared ALU for OP and OP-IMM; funct7[5] selects SUB/SRA, but for immediates only
    // on the shift encoding since ADDI's funct7 bits belong to the immediate.
    assign alu_b   = (opcode == OpReg) ? rs2_val : imm_i;
    assign shamt   = alu_b[4:0];
    assign alu_alt = funct7[5] & ((opcode == OpReg) | (funct3 == 3'b101));

    always_comb begin
        alu_out = '0;
        unique case (funct3)
            3'b000: alu_out = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << shamt;
            3'b010: alu_out = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {{(XLEN-1){1'b0}}, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: alu_out = alu_alt ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110: alu_out = rs1_val | alu_b;
            3'b111: alu_out = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_val == rs2_val);
            3'b001:  br_cond = (rs1_val != rs2_val);
            3'b100:  br_cond = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond = (rs1_val < rs2_val);
            3'b111:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        result_d  = alu_out;
        next_pc_d = pc_plus4;
        writes_rd = 1'b0;
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OpReg: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
                if (!(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    illegal_d = 1'b1;
                end
            end
            OpImm: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                if (funct3 == 3'b001 && funct7 != 7'h00) illegal_d = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) illegal_d = 1'b1;
            end
            OpLui: begin
                writes_rd = 1'b1;
                result_d  = imm_u;
            end
            OpAuipc: begin
                writes_rd = 1'b1;
                result_d  = pc + imm_u;
            end
            OpJal: begin
                writes_rd = 1'b1;
                result_d  = pc_plus4;
                taken_d   = 1'b1;
                next_pc_d = pc + imm_j;
            end
            OpJalr: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                result_d  = pc_plus4;
                taken_d   = 1'b1;
                next_pc_d = {jalr_sum[XLEN-1:1], 1'b0};
                illegal_d = (funct3 != 3'b000);
            end
            OpBranch: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                result_d  = '0;
                taken_d   = br_cond;
                next_pc_d = br_cond ? pc + imm_b : pc_plus4;
                illegal_d = (funct3[2:1] == 2'b01);
            end
            default: illegal_d = 1'b1;
        endcase

        // Only the register fields the format actually uses are range-checked.
        if (uses_rs1 && 32'(rs1) >= NUM_REGS) illegal_d = 1'b1;
        if (uses_rs2 && 32'(rs2) >= NUM_REGS) illegal_d = 1'b1;
        if (writes_rd && 32'(rd) >= NUM_REGS) illegal_d = 1'b1;

        if (illegal_d) begin
            writes_rd = 1'b0;
            taken_d   = 1'b0;
            next_pc_d = pc_plus4;
        end
    end

    assign we_d = writes_rd & (rd != 5'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid        <= 1'b0;
            out_rd           <= '0;
            out_result       <= '0;
            out_we           <= 1'b0;
            out_branch_taken <= 1'b0;
            out_next_pc      <= '0;
            out_illegal      <= 1'b0;
            retire_count     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            out_rd           <= rd;
            out_result       <= result_d;
            out_we           <= we_d;
            out_branch_taken <= taken_d;
            out_next_pc      <= next_pc_d;
            out_illegal      <= illegal_d;
            if (we_d) regs[rd[RegIdxW-1:0]] <= result_d;
            if (!illegal_d) retire_count <= retire_count + CNT_WIDTH'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: a reference ISA model fills a scoreboard at
// accept time; a negedge monitor pops and compares every consumed result. A second
// instance (16 registers, 3-bit counter) covers RV32E index checks and counter wrap.
module tb_execute_stage;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] instruction = '0, pc = '0;
    logic [4:0]  out_rd;
    logic [31:0] out_result, out_next_pc, retire_count;
    logic        out_we, out_branch_taken, out_illegal;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16;
    logic [31:0] instr16 = '0;
    logic [31:0] pc16 = 32'h40;
    logic [4:0]  out_rd16;
    logic [31:0] out_result16, out_next_pc16;
    logic        out_we16, out_taken16, out_illegal16;
    logic [2:0]  retire16;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        res_chk;
        logic        we;
        logic        taken;
        logic [31:0] npc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    logic [31:0] mreg [32];
    int          total = 0;
    int          bad = 0;
    int unsigned exp_retire = 0;
    bit          rand_on = 1'b0;

    always #5 clock = ~clock;

    execute_stage dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instruction      (instruction),
        .pc               (pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_rd           (out_rd),
        .out_result       (out_result),
        .out_we           (out_we),
        .out_branch_taken (out_branch_taken),
        .out_next_pc      (out_next_pc),
        .out_illegal      (out_illegal),
        .retire_count     (retire_count)
    );

    execute_stage #(.XLEN(32), .NUM_REGS(16), .CNT_WIDTH(3)) dut16 (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid16),
        .in_ready         (in_ready16),
        .instruction      (instr16),
        .pc               (pc16),
        .out_valid        (out_valid16),
        .out_ready        (1'b1),
        .out_rd           (out_rd16),
        .out_result       (out_result16),
        .out_we           (out_we16),
        .out_branch_taken (out_taken16),
        .out_next_pc      (out_next_pc16),
        .out_illegal      (out_illegal16),
        .retire_count     (retire16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OpReg};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpBranch};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
    endfunction

    // Architectural reference model; updates the shadow register file.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv);
        exp_t        e;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b, ii, res;
        logic        wr, cond;
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
        rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
        a = mreg[rs1]; b = mreg[rs2];
        ii = {{20{ins[31]}}, ins[31:20]};
        e = '0; e.rd = rd; e.npc = pcv + 32'd4;
        res = '0; wr = 1'b0; cond = 1'b0;
        case (op)
            OpReg: begin
                wr = 1'b1;
                case ({f7, f3})
                    10'h000: res = a + b;
                    10'h100: res = a - b;
                    10'h001: res = a << b[4:0];
                    10'h002: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    10'h003: res = (a < b) ? 32'd1 : 32'd0;
                    10'h004: res = a ^ b;
                    10'h005: res = a >> b[4:0];
                    10'h105: res = $signed(a) >>> b[4:0];
                    10'h006: res = a | b;
                    10'h007: res = a & b;
                    default: e.ill = 1'b1;
                endcase
            end
            OpImm: begin
                wr = 1'b1;
                case (f3)
                    3'd0: res = a + ii;
                    3'd2: res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < ii) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ ii;
                    3'd6: res = a | ii;
                    3'd7: res = a & ii;
                    3'd1: if (f7 == 7'h00) res = a << ins[24:20]; else e.ill = 1'b1;
                    default: begin
                        if (f7 == 7'h00) res = a >> ins[24:20];
                        else if (f7 == 7'h20) res = $signed(a) >>> ins[24:20];
                        else e.ill = 1'b1;
                    end
                endcase
            end
            OpLui:   begin wr = 1'b1; res = {ins[31:12], 12'h0}; end
            OpAuipc: begin wr = 1'b1; res = pcv + {ins[31:12], 12'h0}; end
            OpJal: begin
                wr = 1'b1; res = pcv + 32'd4; e.taken = 1'b1;
                e.npc = pcv + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OpJalr: begin
                wr = 1'b1; res = pcv + 32'd4; e.taken = 1'b1;
                e.npc = (a + ii) & ~32'd1;
                if (f3 != 3'd0) e.ill = 1'b1;
            end
            OpBranch: begin
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = $signed(a) < $signed(b);
                    3'd5: cond = $signed(a) >= $signed(b);
                    3'd6: cond = a < b;
                    3'd7: cond = a >= b;
                    default: e.ill = 1'b1;
                endcase
                e.taken = cond;
                if (cond) e.npc = pcv + {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                                         ins[11:8], 1'b0};
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.taken = 1'b0; e.npc = pcv + 32'd4;
        end else begin
            e.we = wr && (rd != 5'd0);
            e.res = res;
            e.res_chk = wr;
            if (e.we) mreg[rd] = res;
        end
        return e;
    endfunction

    // Offer one instruction; the expectation is queued on the cycle it is accepted.
    // hand=1 replaces the model's result with a hand-derived constant.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pcv, input bit hand,
                         input logic [31:0] hand_res);
        exp_t e;
        bit   got = 1'b0;
        instruction = ins; pc = pcv; in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(ins, pcv);
        if (hand) e.res = hand_res;
        sb.push_back(e);
        if (!e.ill) exp_retire++;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic issue16(input logic [31:0] ins);
        instr16 = ins; in_valid16 = 1'b1;
        @(posedge clock); #1;
        in_valid16 = 1'b0;
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [2:0]  f3 = r[4:2];
        logic [4:0]  rd = {2'b00, r[7:5]};
        logic [4:0]  rs1 = {2'b00, r[10:8]};
        logic [4:0]  rs2 = {2'b00, r[13:11]};
        logic [6:0]  f7;
        if (r[0]) begin
            f7 = (r[1] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
            return enc_r(f7, rs2, rs1, f3, rd);
        end
        if (f3 == 3'd1) return enc_i({7'h00, r[18:14]}, rs1, f3, rd, OpImm);
        if (f3 == 3'd5) return enc_i({(r[1] ? 7'h20 : 7'h00), r[18:14]}, rs1, f3, rd, OpImm);
        return enc_i(r[30:19], rs1, f3, rd, OpImm);
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                check_eq("we", 32'(out_we), 32'(me.we));
                check_eq("taken", 32'(out_branch_taken), 32'(me.taken));
                check_eq("next_pc", out_next_pc, me.npc);
                check_eq("illegal", 32'(out_illegal), 32'(me.ill));
                if (me.res_chk) begin
                    check_eq("result", out_result, me.res);
                    check_eq("rd", 32'(out_rd), 32'(me.rd));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clock); #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_retire", retire_count, 32'd0);
        check_eq("rst_result", out_result, 32'd0);
        check_eq("rst_next_pc", out_next_pc, 32'd0);
        check_eq("rst_flags", {29'd0, out_we, out_branch_taken, out_illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;

        // Back-to-back dependent ALU ops.
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OpImm), 32'h0, 1'b1, 32'd5);
        issue(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OpImm), 32'h4, 1'b1, 32'hFFFF_FFFD);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h8, 1'b1, 32'd2);
        drain();
        check_eq("retire_3", retire_count, 32'd3);

        // Shifts and compares on a negative operand.
        issue(enc_u(20'h80000, 5'd1, OpLui), 32'hC, 1'b1, 32'h8000_0000);
        issue(enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd4, OpImm), 32'h10, 1'b1, 32'hF800_0000);
        issue(enc_i({7'h00, 5'd4}, 5'd1, 3'd5, 5'd6, OpImm), 32'h14, 1'b1, 32'h0800_0000);
        issue(enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd5), 32'h18, 1'b1, 32'd1);
        issue(enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd7), 32'h1C, 1'b1, 32'd0);

        // Branches.
        issue(enc_b(13'd16, 5'd0, 5'd0, 3'd0), 32'h100, 1'b0, '0);
        issue(enc_b(13'd16, 5'd0, 5'd0, 3'd1), 32'h100, 1'b0, '0);
        issue(enc_b(13'h1FF8, 5'd0, 5'd1, 3'd4), 32'h120, 1'b0, '0);
        issue(enc_b(13'h1FF8, 5'd0, 5'd1, 3'd6), 32'h120, 1'b0, '0);
        issue(enc_b(13'h1FF8, 5'd1, 5'd0, 3'd5), 32'h120, 1'b0, '0);

        // Jumps and AUIPC.
        issue(enc_i(12'h400, 5'd0, 3'd0, 5'd2, OpImm), 32'h1F0, 1'b1, 32'h400);
        issue(enc_i(12'd3, 5'd2, 3'd0, 5'd1, OpJalr), 32'h200, 1'b1, 32'h204);
        issue(enc_j(21'h20, 5'd8), 32'h300, 1'b1, 32'h304);
        issue(enc_u(20'h00001, 5'd3, OpAuipc), 32'h10, 1'b1, 32'h1010);

        // Illegal encodings leave the register file alone.
        issue(enc_i(12'h055, 5'd0, 3'd0, 5'd9, OpImm), 32'h400, 1'b1, 32'h55);
        issue(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd9), 32'h404, 1'b0, '0);
        issue(32'h0000_0000, 32'h408, 1'b0, '0);
        issue(enc_i({7'h20, 5'd1}, 5'd1, 3'd1, 5'd9, OpImm), 32'h40C, 1'b0, '0);
        issue(enc_r(7'h00, 5'd0, 5'd9, 3'd0, 5'd10), 32'h410, 1'b1, 32'h55);
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0, OpImm), 32'h414, 1'b0, '0);
        issue(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd11), 32'h418, 1'b1, 32'd0);
        drain();
        check_eq("retire_dir", retire_count, 32'(exp_retire));

        // Backpressure: result held for three cycles, then released.
        out_ready = 1'b0;
        issue(enc_i(12'd77, 5'd0, 3'd0, 5'd6, OpImm), 32'h500, 1'b1, 32'd77);
        fork
            issue(enc_i(12'd99, 5'd0, 3'd0, 5'd6, OpImm), 32'h504, 1'b1, 32'd99);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                    check_eq("stall_valid", 32'(out_valid), 32'd1);
                    check_eq("stall_result", out_result, 32'd77);
                    check_eq("stall_retire", retire_count, 32'(exp_retire));
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
                @(negedge clock);
                check_eq("release_in_ready", 32'(in_ready), 32'd1);
            end
        join
        issue(enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd7), 32'h508, 1'b1, 32'd99);
        drain();

        // Random ALU traffic with random downstream backpressure.
        for (int i = 1; i < 8; i++) begin
            issue(enc_u(20'($urandom), 5'(i), OpLui), 32'h800, 1'b0, '0);
            issue(enc_i(12'($urandom), 5'(i), 3'd0, 5'(i), OpImm), 32'h804, 1'b0, '0);
        end
        rand_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++) issue(rand_instr(), 32'h1000 + 32'(k * 4), 1'b0, '0);
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clock); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check_eq("retire_rand", retire_count, 32'(exp_retire));

        // Reset while a result is stalled discards it.
        out_ready = 1'b0;
        issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1, OpImm), 32'h600, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_retire", retire_count, 32'd0);
        check_eq("midrst_result", out_result, 32'd0);
        sb.delete();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        exp_retire = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("postrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        issue(enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd2), 32'h700, 1'b1, 32'd0);
        issue(enc_i(12'd5, 5'd2, 3'd0, 5'd3, OpImm), 32'h704, 1'b1, 32'd5);
        drain();
        check_eq("retire_post", retire_count, 32'd2);

        // 16-register instance with a 3-bit retire counter.
        issue16(enc_i(12'd9, 5'd0, 3'd0, 5'd1, OpImm));
        check_eq("e_addi_res", out_result16, 32'd9);
        check_eq("e_retire1", 32'(retire16), 32'd1);
        issue16(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd17));
        check_eq("e_rd17_ill", 32'(out_illegal16), 32'd1);
        check_eq("e_rd17_we", 32'(out_we16), 32'd0);
        check_eq("e_rd17_npc", out_next_pc16, 32'h44);
        check_eq("e_rd17_retire", 32'(retire16), 32'd1);
        issue16(enc_r(7'h00, 5'd18, 5'd1, 3'd0, 5'd3));
        check_eq("e_rs18_ill", 32'(out_illegal16), 32'd1);
        check_eq("e_rs18_retire", 32'(retire16), 32'd1);
        issue16(enc_i(12'd7, 5'd0, 3'd0, 5'd0, OpImm));
        check_eq("e_x0_we", 32'(out_we16), 32'd0);
        check_eq("e_x0_ill", 32'(out_illegal16), 32'd0);
        issue16(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5));
        check_eq("e_x0_read", out_result16, 32'd0);
        check_eq("e_retire3", 32'(retire16), 32'd3);
        issue16(enc_i(12'd1, 5'd1, 3'd0, 5'd15, OpImm));
        check_eq("e_x15_res", out_result16, 32'd10);
        check_eq("e_x15_we", 32'(out_we16), 32'd1);
        for (int i = 0; i < 3; i++) issue16(enc_i(12'd1, 5'd0, 3'd0, 5'd4, OpImm));
        check_eq("e_retire7", 32'(retire16), 32'd7);
        issue16(enc_i(12'd1, 5'd0, 3'd0, 5'd4, OpImm));
        check_eq("e_retire_wrap", 32'(retire16), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter XLEN, default 32, data-path width; only 32 is legal, so shift amounts are 5 bits.
REQ-002 Parameter NUM_REGS, default 32, architectural register count; legal values are 16 (RV32E) and 32.
REQ-003 Parameter CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  instruction/pc presented.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 instruction  input  32  RV32I encoding.
REQ-009 pc  input  XLEN  address of instruction.
REQ-010 out_valid  output  1  result register holds an executed instruction.
REQ-011 out_ready  input  1  downstream consumes result.
REQ-012 out_rd  output  5  destination index.
REQ-013 out_result  output  XLEN  ALU result, or pc+4 for jumps.
REQ-014 out_we  output  1  write-back performed for this instruction.
REQ-015 out_branch_taken  output  1  control transfer taken.
REQ-016 out_next_pc  output  XLEN  next fetch address.
REQ-017 out_illegal  output  1  unsupported opcode/funct or register index >= NUM_REGS.
REQ-018 retire_count  output  CNT_WIDTH  number of accepted non-illegal instructions.

Function
REQ-019 in_ready SHALL equal (!out_valid | out_ready); input accepted when in_valid & in_ready.
REQ-020 An accepted instruction SHALL appear on the out_* register the next cycle: 1-cycle latency, full throughput.
REQ-021 out_valid SHALL set on accept, clear when out_ready & !accept, and hold with all out_* stable while out_valid & !out_ready.
REQ-022 Operands SHALL be read combinationally from the internal NUM_REGS x XLEN register file at accept time.
REQ-023 The register-file write SHALL occur at the accept edge, so the next instruction reads the updated value without forwarding or stall.
REQ-024 Reads of x0 SHALL return 0; writes to x0 SHALL be dropped, with out_we=0.
REQ-025 Supported: R-type ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; I-type ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; LUI; AUIPC; JAL; JALR; BEQ BNE BLT BGE BLTU BGEU.
REQ-026 Arithmetic SHALL be modulo 2^XLEN; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned; immediates sign-extended.
REQ-027 JAL/JALR SHALL write pc+4, set out_branch_taken=1 and out_next_pc=target; JALR target bit 0 is cleared.
REQ-028 Branches SHALL set out_we=0 and out_next_pc=taken ? pc+imm : pc+4.
REQ-029 For all other instructions, out_next_pc SHALL be pc+4 and out_branch_taken 0.
REQ-030 Illegal instructions SHALL set out_illegal=1, out_we=0, out_next_pc=pc+4, leave the register file untouched and not increment retire_count.
REQ-031 With NUM_REGS=16, any rs1/rs2/rd index of 16 or above SHALL be treated as illegal.
REQ-032 retire_count SHALL increment on accepted legal instructions and wrap from 2^CNT_WIDTH-1 to 0.
REQ-033 Simultaneous out_ready and accept SHALL replace the result register in the same edge, leaving out_valid at 1.

Reset
REQ-034 Reset SHALL asynchronously clear out_valid, out_we, out_branch_taken, out_illegal, out_rd, out_result, out_next_pc, retire_count and all registers to 0.
REQ-035 Reset asserted mid-stall SHALL discard the held result; in_ready SHALL be 1 from the first cycle after reset is released.

Verification
REQ-036 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 back-to-back -> out_result 5, 0xFFFFFFFD, 2 on consecutive cycles; retire_count=3.
REQ-037 x1=0x80000000: SRAI x4,x1,4 -> 0xF8000000; SRLI -> 0x08000000; SLT x5,x1,x0 -> 1; SLTU -> 0.
REQ-038 pc=0x100, BEQ x0,x0,+16 -> taken=1, next_pc=0x110, we=0; BNE x0,x0,+16 -> taken=0, next_pc=0x104.
REQ-039 pc=0x200, JALR x1,x2,3 with x2=0x400 -> out_result=0x204, out_next_pc=0x402.
REQ-040 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no register writes; release -> next instruction accepted the same cycle.
REQ-041 NUM_REGS=16: ADD x17,x1,x2 -> out_illegal=1, out_we=0, retire_count unchanged; ADDI x0,x0,7 -> out_we=0, x0 still reads 0.
